// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and helpers for the register file / scoreboard slice.
// No logic: parameters and a constant function only.
// Imported by the top and by every read-port instance.
package regfile_scoreboard_pkg;

  // Default register data width.
  localparam int DEFAULT_XLEN  = 32;

  // Default register count. Must be a power of two and at least 2.
  localparam int DEFAULT_NREGS = 32;

  // Address width needed to index a register file of nregs entries.
  function automatic int addr_width(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: decodes the address, applies write-first bypass and looks up the busy bit.
// Latency: combinational, zero cycles.
// Backpressure: none; the port always answers, and busy is reported for the consumer to stall on.
module regfile_read_port
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int NREGS = DEFAULT_NREGS,
  parameter int AW    = addr_width(NREGS)
) (
  input  logic [AW-1:0]         src,
  input  logic [NREGS*XLEN-1:0] regs_flat,
  input  logic [NREGS-1:0]      busy,
  input  logic [AW-1:0]         dest,
  input  logic                  write_enable,
  input  logic [XLEN-1:0]       data_in,
  output logic [XLEN-1:0]       rd_data,
  output logic                  rd_busy
);

  logic wr_match;
  logic src_is_zero;

  // Flags a same-cycle writeback to the register this port is reading.
  always_comb begin
    src_is_zero = (src == '0);
    wr_match    = write_enable && (dest == src);
  end

  // Read data: x0 is hard-wired to zero, a same-cycle write to this register is forwarded.
  always_comb begin
    rd_data = '0;
    if (!src_is_zero) begin
      if (wr_match) begin
        rd_data = data_in;
      end else begin
        rd_data = regs_flat[int'(src)*XLEN +: XLEN];
      end
    end
  end

  // Busy lookup: a writeback arriving this cycle already resolves the dependency.
  always_comb begin
    rd_busy = busy[src] && !wr_match;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Flop-based register file with a per-register busy scoreboard for in-flight writebacks.
// Latency: reads and busy/ready flags are combinational; writes, reservations and busy_count land at the next edge.
// Backpressure: rsv_ready drops while rsv_dest is still busy (WAW), unless a writeback to it lands this cycle.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int NREGS = DEFAULT_NREGS,
  parameter int NREAD = 2,
  parameter int AW    = addr_width(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   src,
  output logic [NREAD*XLEN-1:0] out,
  output logic [NREAD-1:0]      src_busy,
  input  logic [AW-1:0]         dest,
  input  logic                  write_enable,
  input  logic [XLEN-1:0]       data_in,
  input  logic                  rsv_valid,
  input  logic [AW-1:0]         rsv_dest,
  output logic                  rsv_ready,
  input  logic                  flush,
  output logic [AW:0]           busy_count
);

  // Register storage and scoreboard. Entry 0 is never written and never marked busy.
  logic [NREGS*XLEN-1:0] regs_flat;
  logic [NREGS-1:0]      busy;
  logic [NREGS-1:0]      busy_nxt;
  logic [AW:0]           count_nxt;

  logic wr_live;
  logic wr_clears;
  logic rsv_fire;
  logic cnt_inc;
  logic cnt_dec;

  // Decode the writeback and the reservation handshake for this cycle.
  always_comb begin
    wr_live   = write_enable && (dest != '0);
    wr_clears = wr_live && busy[dest];
    rsv_ready = !busy[rsv_dest] || (write_enable && (dest == rsv_dest)) || (rsv_dest == '0);
    // x0 always accepts, but accepting it has no effect on the scoreboard.
    rsv_fire  = rsv_valid && rsv_ready && (rsv_dest != '0);
  end

  // Next busy vector: writeback clears, reservation sets (and wins on a tie), flush clears all.
  always_comb begin
    busy_nxt = busy;
    if (wr_clears) begin
      busy_nxt[dest] = 1'b0;
    end
    if (rsv_fire) begin
      busy_nxt[rsv_dest] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
  end

  // Incremental popcount. A reservation only adds a bit if its target was idle;
  // a writeback only removes one if the same register is not re-reserved this cycle.
  always_comb begin
    cnt_inc   = rsv_fire && !busy[rsv_dest];
    cnt_dec   = wr_clears && !(rsv_fire && (rsv_dest == dest));
    count_nxt = busy_count;
    if (flush) begin
      count_nxt = '0;
    end else if (cnt_inc && !cnt_dec) begin
      count_nxt = busy_count + 1'b1;
    end else if (cnt_dec && !cnt_inc) begin
      count_nxt = busy_count - 1'b1;
    end
  end

  // Register data: reset clears everything, otherwise a live writeback updates its entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_flat <= '0;
    end else if (wr_live) begin
      regs_flat[int'(dest)*XLEN +: XLEN] <= data_in;
    end
  end

  // Scoreboard state: reset has priority over flush, writeback and reservation.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= count_nxt;
    end
  end

  // One independent read port per requested read lane.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    regfile_read_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_rd (
      .src          (src[k*AW +: AW]),
      .regs_flat    (regs_flat),
      .busy         (busy),
      .dest         (dest),
      .write_enable (write_enable),
      .data_in      (data_in),
      .rd_data      (out[k*XLEN +: XLEN]),
      .rd_busy      (src_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, bypass, reservation, WAW stall, x0 and flush.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
// Every scenario is a task with its own inline comparisons.
module tb_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                  clk;
  logic                  reset;
  logic [NREAD*AW-1:0]   src;
  logic [NREAD*XLEN-1:0] out;
  logic [NREAD-1:0]      src_busy;
  logic [AW-1:0]         dest;
  logic                  write_enable;
  logic [XLEN-1:0]       data_in;
  logic                  rsv_valid;
  logic [AW-1:0]         rsv_dest;
  logic                  rsv_ready;
  logic                  flush;
  logic [AW:0]           busy_count;

  int checks;
  int errors;

  regfile_scoreboard #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NREAD (NREAD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src          (src),
    .out          (out),
    .src_busy     (src_busy),
    .dest         (dest),
    .write_enable (write_enable),
    .data_in      (data_in),
    .rsv_valid    (rsv_valid),
    .rsv_dest     (rsv_dest),
    .rsv_ready    (rsv_ready),
    .flush        (flush),
    .busy_count   (busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and move to the drive point just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write_enable = 1'b0;
    dest         = '0;
    data_in      = '0;
    rsv_valid    = 1'b0;
    rsv_dest     = '0;
    flush        = 1'b0;
  endtask

  // Reset while a write and a reservation to x3 are also requested: reset must win.
  task automatic test_reset();
    logic [AW-1:0] a;
    idle_inputs();
    src          = '0;
    reset        = 1'b1;
    write_enable = 1'b1;
    dest         = 5'd3;
    data_in      = 32'hFFFF_FFFF;
    rsv_valid    = 1'b1;
    rsv_dest     = 5'd3;
    step();
    step();
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (busy_count !== 6'd0) begin
      errors++;
      $display("FAIL reset_busy_count: got %0d expected 0", busy_count);
    end
    for (int i = 0; i < NREGS; i++) begin
      a        = i[AW-1:0];
      src      = {a, a};
      rsv_dest = a;
      #1;
      checks++;
      if (out !== 64'h0) begin
        errors++;
        $display("FAIL reset_out x%0d: got %h expected 0", i, out);
      end
      checks++;
      if (src_busy !== 2'b00) begin
        errors++;
        $display("FAIL reset_src_busy x%0d: got %b expected 00", i, src_busy);
      end
      checks++;
      if (rsv_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_rsv_ready x%0d: got %b expected 1", i, rsv_ready);
      end
    end
    rsv_dest = '0;
  endtask

  // Write x5 while reading it on both ports: bypass this cycle, stored value next cycle.
  task automatic test_bypass();
    idle_inputs();
    write_enable = 1'b1;
    dest         = 5'd5;
    data_in      = 32'hDEAD_BEEF;
    src          = {5'd5, 5'd5};
    #1;
    checks++;
    if (out[0 +: XLEN] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h expected deadbeef", out[0 +: XLEN]);
    end
    checks++;
    if (out[XLEN +: XLEN] !== out[0 +: XLEN]) begin
      errors++;
      $display("FAIL bypass_ports_agree: got %h expected %h", out[XLEN +: XLEN], out[0 +: XLEN]);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (out[0 +: XLEN] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_next_cycle: got %h expected deadbeef", out[0 +: XLEN]);
    end
    checks++;
    if (out[XLEN +: XLEN] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_port1_stored: got %h expected deadbeef", out[XLEN +: XLEN]);
    end
  endtask

  // Reserve x7, observe busy, then a writeback clears busy combinationally and the count next edge.
  task automatic test_reserve();
    idle_inputs();
    src       = {5'd7, 5'd0};
    rsv_valid = 1'b1;
    rsv_dest  = 5'd7;
    #1;
    checks++;
    if (rsv_ready !== 1'b1) begin
      errors++;
      $display("FAIL reserve_ready: got %b expected 1", rsv_ready);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (src_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL reserve_src_busy: got %b expected 1", src_busy[1]);
    end
    checks++;
    if (busy_count !== 6'd1) begin
      errors++;
      $display("FAIL reserve_count: got %0d expected 1", busy_count);
    end
    write_enable = 1'b1;
    dest         = 5'd7;
    data_in      = 32'h12;
    #1;
    checks++;
    if (src_busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL writeback_src_busy: got %b expected 0", src_busy[1]);
    end
    checks++;
    if (out[XLEN +: XLEN] !== 32'h12) begin
      errors++;
      $display("FAIL writeback_bypass: got %h expected 12", out[XLEN +: XLEN]);
    end
    checks++;
    if (busy_count !== 6'd1) begin
      errors++;
      $display("FAIL writeback_count_before_edge: got %0d expected 1", busy_count);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (busy_count !== 6'd0) begin
      errors++;
      $display("FAIL writeback_count_after: got %0d expected 0", busy_count);
    end
    checks++;
    if (out[XLEN +: XLEN] !== 32'h12 || src_busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL writeback_stored: got %h/%b expected 12/0", out[XLEN +: XLEN], src_busy[1]);
    end
  endtask

  // Double reservation of x7 stalls; with a same-cycle writeback it is accepted and x7 stays busy.
  task automatic test_waw();
    idle_inputs();
    src       = {5'd7, 5'd0};
    rsv_valid = 1'b1;
    rsv_dest  = 5'd7;
    step();
    #1;
    checks++;
    if (rsv_ready !== 1'b0) begin
      errors++;
      $display("FAIL waw_stall: got %b expected 0", rsv_ready);
    end
    step();
    #1;
    checks++;
    if (busy_count !== 6'd1) begin
      errors++;
      $display("FAIL waw_count_held: got %0d expected 1", busy_count);
    end
    write_enable = 1'b1;
    dest         = 5'd7;
    data_in      = 32'h34;
    #1;
    checks++;
    if (rsv_ready !== 1'b1) begin
      errors++;
      $display("FAIL waw_ready_with_wb: got %b expected 1", rsv_ready);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (src_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL waw_stays_busy: got %b expected 1", src_busy[1]);
    end
    checks++;
    if (busy_count !== 6'd1) begin
      errors++;
      $display("FAIL waw_count: got %0d expected 1", busy_count);
    end
    checks++;
    if (out[XLEN +: XLEN] !== 32'h34) begin
      errors++;
      $display("FAIL waw_data_written: got %h expected 34", out[XLEN +: XLEN]);
    end
    // Retire x7 so later scenarios start from an empty scoreboard.
    write_enable = 1'b1;
    dest         = 5'd7;
    data_in      = 32'h34;
    step();
    idle_inputs();
    #1;
    checks++;
    if (busy_count !== 6'd0) begin
      errors++;
      $display("FAIL waw_retire_count: got %0d expected 0", busy_count);
    end
  endtask

  // x0: reservation always accepted but has no effect, writes are dropped.
  task automatic test_x0();
    idle_inputs();
    src          = {5'd0, 5'd0};
    rsv_valid    = 1'b1;
    rsv_dest     = 5'd0;
    write_enable = 1'b1;
    dest         = 5'd0;
    data_in      = 32'hFF;
    #1;
    checks++;
    if (rsv_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_rsv_ready: got %b expected 1", rsv_ready);
    end
    checks++;
    if (out !== 64'h0) begin
      errors++;
      $display("FAIL x0_out_same_cycle: got %h expected 0", out);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (busy_count !== 6'd0) begin
      errors++;
      $display("FAIL x0_count: got %0d expected 0", busy_count);
    end
    checks++;
    if (out !== 64'h0 || src_busy !== 2'b00) begin
      errors++;
      $display("FAIL x0_after: got %h/%b expected 0/00", out, src_busy);
    end
  endtask

  // Reserve x1..x4, then flush with a reservation on x9 and a write to x10.
  task automatic test_flush();
    logic [AW-1:0] r;
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      r         = i[AW-1:0];
      rsv_valid = 1'b1;
      rsv_dest  = r;
      step();
      #1;
      checks++;
      if (busy_count !== i[AW:0]) begin
        errors++;
        $display("FAIL flush_fill_count x%0d: got %0d expected %0d", i, busy_count, i);
      end
    end
    rsv_valid    = 1'b1;
    rsv_dest     = 5'd9;
    flush        = 1'b1;
    write_enable = 1'b1;
    dest         = 5'd10;
    data_in      = 32'h55;
    step();
    idle_inputs();
    src      = {5'd10, 5'd9};
    rsv_dest = 5'd9;
    #1;
    checks++;
    if (busy_count !== 6'd0) begin
      errors++;
      $display("FAIL flush_count: got %0d expected 0", busy_count);
    end
    checks++;
    if (src_busy !== 2'b00) begin
      errors++;
      $display("FAIL flush_src_busy: got %b expected 00", src_busy);
    end
    checks++;
    if (rsv_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_x9_ready: got %b expected 1", rsv_ready);
    end
    checks++;
    if (out[XLEN +: XLEN] !== 32'h55) begin
      errors++;
      $display("FAIL flush_write_kept: got %h expected 55", out[XLEN +: XLEN]);
    end
    src = {5'd5, 5'd1};
    #1;
    checks++;
    if (src_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL flush_x1_idle: got %b expected 0", src_busy[0]);
    end
    checks++;
    if (out[XLEN +: XLEN] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL flush_data_intact: got %h expected deadbeef", out[XLEN +: XLEN]);
    end
  endtask

  // Consecutive writes to x1 and x2, then read both on independent ports.
  task automatic test_back_to_back();
    idle_inputs();
    write_enable = 1'b1;
    dest         = 5'd1;
    data_in      = 32'h1111_0001;
    step();
    dest    = 5'd2;
    data_in = 32'h2222_0002;
    src     = {5'd2, 5'd1};
    #1;
    checks++;
    if (out !== {32'h2222_0002, 32'h1111_0001}) begin
      errors++;
      $display("FAIL b2b_mixed: got %h expected 2222000211110001", out);
    end
    step();
    idle_inputs();
    src = {5'd1, 5'd2};
    #1;
    checks++;
    if (out !== {32'h1111_0001, 32'h2222_0002}) begin
      errors++;
      $display("FAIL b2b_swapped: got %h expected 1111000122220002", out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bypass();
    test_reserve();
    test_waw();
    test_x0();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
